pc_ctrl: RTL and testbench

Fetch-stage controller that sequences the program counter register. Each cycle it drives the PC's write enable, revert, select and next-value inputs from hazard, branch-redirect, trap, halt and instruction-memory handshake events. It also generates IF/ID flush strobes and keeps saturating stall and redirect counters. It sits between the hazard unit / EX branch resolution and the PC register plus instruction memory port.

---
 rtl/pc_ctrl_pkg.sv | 36 +++
 rtl/pc_ctrl_sat.sv | 24 ++
 rtl/pc_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pc_ctrl.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC controller.
// Holds the controller state enum, the pc_sel encodings, the counter widths
// and the helper that turns a pc_sel code into the PC data-input value.
package pc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_RUN,
        ST_WAIT_MEM,
        ST_FLUSH,
        ST_HALT
    } state_t;

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_TRAP   = 2'b10;
    localparam logic [1:0] SEL_HOLD   = 2'b11;

    localparam int STALL_CNT_W = 32;
    localparam int REDIR_CNT_W = 16;

    // Value presented on the PC data input for a given select code.
    // SEQ wraps naturally modulo 2^32.
    function automatic logic [31:0] pc_mux(input logic [1:0]  sel,
                                           input logic [31:0] cur,
                                           input logic [31:0] target,
                                           input logic [31:0] tvec);
        case (sel)
            SEL_SEQ:    return cur + 32'd4;
            SEL_BRANCH: return target;
            SEL_TRAP:   return tvec;
            default:    return cur;
        endcase
    endfunction

endpackage

// File: rtl/pc_ctrl_sat.sv
// sat_counter: saturating up-counter.
// Ports:
//   clk   - clock, state updates on rising edge
//   clear - synchronous clear to zero (wins over inc)
//   inc   - add one this cycle unless already at all-ones
//   count - current count value
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-stage controller that sequences the program counter.
// Decides each cycle whether the PC advances, holds, steps back, takes a
// branch target or jumps to the trap vector, and squashes IF/ID after any
// change of flow.
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   pc_cur              - current PC register value
//   stall, replay       - hazard unit hold / step-back requests
//   redirect_valid/_pc  - taken branch or jump from EX and its target
//   trap_req, halt_req  - trap and ebreak requests
//   imem_ready          - instruction memory handshake
//   pc_we, pc_rev       - PC register write enable / revert (PC-4)
//   pc_sel, pc_next     - select code and data value for the PC register
//   imem_req, if_valid  - fetch request / fetched word is real
//   flush_if, flush_id  - squash strobes for the IF and ID registers
//   misalign            - pulse when a redirect target is not word aligned
//   trap_epc            - PC captured on trap or misaligned redirect
//   halted              - controller is in HALT
//   stall_cnt           - saturating stalled-cycle count
//   redirect_cnt        - saturating redirect + trap count
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            pc_cur,
    input  logic                   stall,
    input  logic                   replay,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    input  logic                   trap_req,
    input  logic                   halt_req,
    input  logic                   imem_ready,
    output logic                   pc_we,
    output logic                   pc_rev,
    output logic [1:0]             pc_sel,
    output logic [31:0]            pc_next,
    output logic                   imem_req,
    output logic                   if_valid,
    output logic                   flush_if,
    output logic                   flush_id,
    output logic                   misalign,
    output logic [31:0]            trap_epc,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic [REDIR_CNT_W-1:0] redirect_cnt
);

    // The flush counter starts one below the bubble count so that FLUSH
    // lasts exactly FLUSH_CYCLES cycles (exit on the cycle it reads zero).
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t      state, state_nx;
    logic [2:0]  fcnt, fcnt_nx;
    logic [31:0] epc_nx;
    logic        stall_inc, redir_inc;
    logic        target_misaligned;

    assign target_misaligned = (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_BOOT;
            fcnt     <= '0;
            trap_epc <= '0;
        end else begin
            state    <= state_nx;
            fcnt     <= fcnt_nx;
            trap_epc <= epc_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        fcnt_nx   = fcnt;
        epc_nx    = trap_epc;
        pc_we     = 1'b0;
        pc_rev    = 1'b0;
        pc_sel    = SEL_HOLD;
        imem_req  = 1'b0;
        if_valid  = 1'b0;
        flush_if  = 1'b0;
        flush_id  = 1'b0;
        misalign  = 1'b0;
        halted    = 1'b0;
        stall_inc = 1'b0;
        redir_inc = 1'b0;

        if (rst) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
        end else begin
            case (state)
                ST_BOOT: begin
                    imem_req = 1'b1;
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                    state_nx = ST_RUN;
                end

                ST_RUN, ST_WAIT_MEM: begin
                    imem_req  = 1'b1;
                    // Every WAIT_MEM cycle is a lost fetch slot, whatever else happens.
                    stall_inc = (state == ST_WAIT_MEM) || stall || replay;
                    if (halt_req) begin
                        imem_req = 1'b0;
                        state_nx = ST_HALT;
                    end else if (trap_req || redirect_valid) begin
                        pc_we     = 1'b1;
                        flush_if  = 1'b1;
                        flush_id  = 1'b1;
                        redir_inc = 1'b1;
                        fcnt_nx   = FLUSH_LOAD;
                        state_nx  = ST_FLUSH;
                        if (trap_req) begin
                            pc_sel = SEL_TRAP;
                            epc_nx = pc_cur;
                        end else if (target_misaligned) begin
                            pc_sel   = SEL_TRAP;
                            misalign = 1'b1;
                            epc_nx   = redirect_pc;
                        end else begin
                            pc_sel = SEL_BRANCH;
                        end
                    end else if (replay && (state == ST_RUN)) begin
                        pc_rev   = 1'b1;
                        flush_if = 1'b1;
                    end else if (stall) begin
                        if_valid = 1'b1;
                    end else if (!imem_ready) begin
                        state_nx = ST_WAIT_MEM;
                    end else begin
                        pc_sel   = SEL_SEQ;
                        pc_we    = 1'b1;
                        if_valid = 1'b1;
                        state_nx = ST_RUN;
                    end
                end

                ST_FLUSH: begin
                    imem_req = 1'b1;
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                    if (trap_req) begin
                        pc_sel    = SEL_TRAP;
                        pc_we     = 1'b1;
                        epc_nx    = pc_cur;
                        redir_inc = 1'b1;
                        fcnt_nx   = FLUSH_LOAD;
                    end else if (fcnt == 3'd0) begin
                        state_nx = ST_RUN;
                    end else begin
                        fcnt_nx = fcnt - 3'd1;
                    end
                end

                ST_HALT: begin
                    halted = 1'b1;
                end

                default: state_nx = ST_BOOT;
            endcase
        end
    end

    assign pc_next = pc_mux(pc_sel, pc_cur, redirect_pc, TRAP_VEC);

    sat_counter #(.WIDTH(STALL_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(REDIR_CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (redir_inc),
        .count (redirect_cnt)
    );

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus a randomized run
// compared against a behavioural model of the fetch controller.
module tb_pc_ctrl;

    localparam logic [31:0] TVEC    = 32'h0000_0100;
    localparam int          FLUSH_N = 2;

    logic        clk = 1'b0;
    logic        rst, stall, replay, redirect_valid, trap_req, halt_req, imem_ready;
    logic [31:0] pc_cur, redirect_pc;
    logic        pc_we, pc_rev, imem_req, if_valid, flush_if, flush_id, misalign, halted;
    logic [1:0]  pc_sel;
    logic [31:0] pc_next, trap_epc, stall_cnt;
    logic [15:0] redirect_cnt;

    logic        pc_load;
    logic [31:0] pc_load_val;

    logic        sc_clear, sc_inc;
    logic [3:0]  sc_count;

    int n_tests = 0;
    int n_fail  = 0;

    pc_ctrl #(.TRAP_VEC(TVEC), .FLUSH_CYCLES(FLUSH_N)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .stall(stall), .replay(replay),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .trap_req(trap_req),
        .halt_req(halt_req), .imem_ready(imem_ready), .pc_we(pc_we), .pc_rev(pc_rev),
        .pc_sel(pc_sel), .pc_next(pc_next), .imem_req(imem_req), .if_valid(if_valid),
        .flush_if(flush_if), .flush_id(flush_id), .misalign(misalign), .trap_epc(trap_epc),
        .halted(halted), .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
    );

    sat_counter #(.WIDTH(4)) u_sc (.clk(clk), .clear(sc_clear), .inc(sc_inc), .count(sc_count));

    always #5 clk = ~clk;

    // Behavioural PC register; pc_load lets a scenario place the PC anywhere.
    always @(posedge clk) begin
        if (pc_load)     pc_cur <= pc_load_val;
        else if (rst)    pc_cur <= 32'd0;
        else if (pc_we)  pc_cur <= pc_next;
        else if (pc_rev) pc_cur <= pc_cur - 32'd4;
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit        we, rev, req, valid, fif, fid, mis, hlt;
        bit [1:0]  sel;
        bit [31:0] nxt;
        bit        n_boot, n_halt, n_wait;
        int        n_flush;
        bit [31:0] n_epc;
        bit        sinc, rinc;
    } mdl_t;

    bit        m_boot = 1'b1, m_halt = 1'b0, m_wait = 1'b0;
    int        m_flush = 0;        // bubble cycles still owed after a redirect/trap
    bit [31:0] m_epc = 32'd0;
    longint    m_scnt = 0, m_rcnt = 0;

    function automatic mdl_t model_eval();
        mdl_t r;
        r.we = 0; r.rev = 0; r.req = 0; r.valid = 0; r.fif = 0; r.fid = 0; r.mis = 0; r.hlt = 0;
        r.sel = 2'b11; r.nxt = 32'd0; r.sinc = 0; r.rinc = 0;
        r.n_boot = m_boot; r.n_halt = m_halt; r.n_wait = m_wait; r.n_flush = m_flush; r.n_epc = m_epc;
        if (rst) begin
            r.fif = 1; r.fid = 1;
            r.n_boot = 1; r.n_halt = 0; r.n_wait = 0; r.n_flush = 0; r.n_epc = 32'd0;
        end else if (m_halt) begin
            r.hlt = 1;
        end else if (m_boot) begin
            r.req = 1; r.fif = 1; r.fid = 1; r.n_boot = 0;
        end else if (m_flush > 0) begin
            r.req = 1; r.fif = 1; r.fid = 1;
            if (trap_req) begin
                r.sel = 2'b10; r.we = 1; r.n_epc = pc_cur; r.rinc = 1; r.n_flush = FLUSH_N;
            end else begin
                r.n_flush = m_flush - 1;
            end
        end else begin
            r.req  = 1;
            r.sinc = m_wait || stall || replay;
            if (halt_req) begin
                r.req = 0; r.n_halt = 1;
            end else if (trap_req || redirect_valid) begin
                r.we = 1; r.fif = 1; r.fid = 1; r.rinc = 1; r.n_flush = FLUSH_N; r.n_wait = 0;
                if (trap_req) begin
                    r.sel = 2'b10; r.n_epc = pc_cur;
                end else if (redirect_pc[1:0] != 2'b00) begin
                    r.sel = 2'b10; r.mis = 1; r.n_epc = redirect_pc;
                end else begin
                    r.sel = 2'b01;
                end
            end else if (replay && !m_wait) begin
                r.rev = 1; r.fif = 1;
            end else if (stall) begin
                r.valid = 1;
            end else if (!imem_ready) begin
                r.n_wait = 1;
            end else begin
                r.sel = 2'b00; r.we = 1; r.valid = 1; r.n_wait = 0;
            end
        end
        case (r.sel)
            2'b00:   r.nxt = pc_cur + 32'd4;
            2'b01:   r.nxt = redirect_pc;
            2'b10:   r.nxt = TVEC;
            default: r.nxt = pc_cur;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin : model_upd
        mdl_t r;
        r = model_eval();
        m_boot  <= r.n_boot;
        m_halt  <= r.n_halt;
        m_wait  <= r.n_wait;
        m_flush <= r.n_flush;
        m_epc   <= r.n_epc;
        if (rst) begin
            m_scnt <= 0;
            m_rcnt <= 0;
        end else begin
            if (r.sinc && m_scnt < 64'h0000_0000_FFFF_FFFF) m_scnt <= m_scnt + 1;
            if (r.rinc && m_rcnt < 65535) m_rcnt <= m_rcnt + 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        stall = 0; replay = 0; redirect_valid = 0; redirect_pc = 32'd0;
        trap_req = 0; halt_req = 0; imem_ready = 1; pc_load = 0; pc_load_val = 32'd0;
    endtask

    // Leaves the bench just after the edge that enters RUN, with PC = 0.
    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic set_pc(input logic [31:0] v);
        pc_load = 1; pc_load_val = v;
        @(posedge clk); #1;
        pc_load = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1; stall = 1; redirect_valid = 1; trap_req = 1; halt_req = 1;
        sc_clear = 1; sc_inc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({pc_we, pc_rev, pc_sel, imem_req, if_valid, flush_if, flush_id} !== 8'b0011_0011) begin
            n_fail++; $display("FAIL reset_ctrl got=%b exp=%b", {pc_we, pc_rev, pc_sel, imem_req, if_valid, flush_if, flush_id}, 8'b0011_0011);
        end
        n_tests++;
        if ({misalign, halted} !== 2'b00 || trap_epc !== 32'd0 || stall_cnt !== 32'd0 || redirect_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_status mis=%b hlt=%b epc=%h sc=%0d rc=%0d exp all zero", misalign, halted, trap_epc, stall_cnt, redirect_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sat_counter();
        sc_clear = 1; sc_inc = 0;
        @(posedge clk); #1;
        sc_clear = 0; sc_inc = 1;
        @(negedge clk);
        n_tests++;
        if (sc_count !== 4'd0) begin n_fail++; $display("FAIL sat_start got=%0d exp=0", sc_count); end
        repeat (20) @(posedge clk);
        #1;
        @(negedge clk);
        n_tests++;
        if (sc_count !== 4'hF) begin n_fail++; $display("FAIL sat_hold got=%0d exp=15", sc_count); end
        sc_clear = 1;
        @(posedge clk); #1;
        sc_clear = 0; sc_inc = 0;
        @(negedge clk);
        n_tests++;
        if (sc_count !== 4'd0) begin n_fail++; $display("FAIL sat_clear got=%0d exp=0", sc_count); end
    endtask

    task automatic test_boot_seq();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        n_tests++;
        if ({pc_we, flush_if, flush_id, imem_req, if_valid} !== 5'b01110) begin
            n_fail++; $display("FAIL boot_ctrl got=%b exp=01110", {pc_we, flush_if, flush_id, imem_req, if_valid});
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (pc_cur !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_pc k=%0d got=%h exp=%h", k, pc_cur, 32'(4 * k)); end
            n_tests++;
            if (pc_we !== 1'b1 || pc_sel !== 2'b00 || pc_next !== 32'(4 * k + 4) || if_valid !== 1'b1) begin
                n_fail++; $display("FAIL seq_ctrl k=%0d we=%b sel=%b next=%h vld=%b exp we=1 sel=00 next=%h vld=1", k, pc_we, pc_sel, pc_next, if_valid, 32'(4 * k + 4));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        do_reset();
        set_pc(32'h20);
        redirect_valid = 1; redirect_pc = 32'h80; stall = 1;
        @(negedge clk);
        n_tests++;
        if (pc_sel !== 2'b01 || pc_next !== 32'h80 || pc_we !== 1'b1 || flush_if !== 1'b1 || flush_id !== 1'b1) begin
            n_fail++; $display("FAIL redir_take sel=%b next=%h we=%b fif=%b fid=%b exp 01/80/1/1/1", pc_sel, pc_next, pc_we, flush_if, flush_id);
        end
        @(posedge clk); #1;
        redirect_valid = 0; stall = 0;
        for (int k = 0; k < FLUSH_N; k++) begin
            @(negedge clk);
            n_tests++;
            if ({flush_if, flush_id, if_valid, pc_we} !== 4'b1100) begin
                n_fail++; $display("FAIL redir_bubble k=%0d got=%b exp=1100", k, {flush_if, flush_id, if_valid, pc_we});
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_tests++;
        if (if_valid !== 1'b1 || pc_cur !== 32'h80 || flush_if !== 1'b0 || redirect_cnt !== 16'd1) begin
            n_fail++; $display("FAIL redir_resume vld=%b pc=%h fif=%b rc=%0d exp 1/80/0/1", if_valid, pc_cur, flush_if, redirect_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_misalign();
        do_reset();
        redirect_valid = 1; redirect_pc = 32'h82;
        @(negedge clk);
        n_tests++;
        if (misalign !== 1'b1 || pc_next !== TVEC || pc_sel !== 2'b10) begin
            n_fail++; $display("FAIL mis_pulse mis=%b next=%h sel=%b exp 1/%h/10", misalign, pc_next, pc_sel, TVEC);
        end
        @(posedge clk); #1;
        redirect_valid = 0;
        @(negedge clk);
        n_tests++;
        if (misalign !== 1'b0 || trap_epc !== 32'h82 || pc_cur !== TVEC) begin
            n_fail++; $display("FAIL mis_after mis=%b epc=%h pc=%h exp 0/82/%h", misalign, trap_epc, pc_cur, TVEC);
        end
        // trap and redirect together: trap wins, EPC is the current PC
        do_reset();
        set_pc(32'h30);
        trap_req = 1; redirect_valid = 1; redirect_pc = 32'h84;
        @(negedge clk);
        n_tests++;
        if (pc_sel !== 2'b10 || pc_next !== TVEC || misalign !== 1'b0) begin
            n_fail++; $display("FAIL trap_vs_redir sel=%b next=%h mis=%b exp 10/%h/0", pc_sel, pc_next, misalign, TVEC);
        end
        @(posedge clk); #1;
        trap_req = 0; redirect_valid = 0;
        @(negedge clk);
        n_tests++;
        if (trap_epc !== 32'h30) begin n_fail++; $display("FAIL trap_vs_redir_epc got=%h exp=30", trap_epc); end
    endtask

    task automatic test_replay_stall();
        do_reset();
        set_pc(32'h10);
        replay = 1;
        @(negedge clk);
        n_tests++;
        if (pc_rev !== 1'b1 || pc_we !== 1'b0 || flush_if !== 1'b1) begin
            n_fail++; $display("FAIL replay_ctrl rev=%b we=%b fif=%b exp 1/0/1", pc_rev, pc_we, flush_if);
        end
        @(posedge clk); #1;
        replay = 0; stall = 1;
        @(negedge clk);
        n_tests++;
        if (pc_cur !== 32'h0C || stall_cnt !== 32'd1) begin
            n_fail++; $display("FAIL replay_after pc=%h sc=%0d exp 0c/1", pc_cur, stall_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            n_tests++;
            if (pc_we !== 1'b0 || if_valid !== 1'b1 || pc_sel !== 2'b11 || pc_next !== 32'h0C) begin
                n_fail++; $display("FAIL stall_hold k=%0d we=%b vld=%b sel=%b next=%h exp 0/1/11/0c", k, pc_we, if_valid, pc_sel, pc_next);
            end
            @(posedge clk); #1;
        end
        stall = 0;
        @(negedge clk);
        n_tests++;
        if (stall_cnt !== 32'd4 || pc_cur !== 32'h0C) begin
            n_fail++; $display("FAIL stall_count sc=%0d pc=%h exp 4/0c", stall_cnt, pc_cur);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wait_mem();
        do_reset();
        set_pc(32'h40);
        imem_ready = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (pc_we !== 1'b0 || if_valid !== 1'b0 || imem_req !== 1'b1) begin
                n_fail++; $display("FAIL wait_ctrl k=%0d we=%b vld=%b req=%b exp 0/0/1", k, pc_we, if_valid, imem_req);
            end
            @(posedge clk); #1;
        end
        trap_req = 1;
        @(negedge clk);
        n_tests++;
        if (pc_sel !== 2'b10 || pc_we !== 1'b1 || pc_next !== TVEC) begin
            n_fail++; $display("FAIL wait_trap sel=%b we=%b next=%h exp 10/1/%h", pc_sel, pc_we, pc_next, TVEC);
        end
        @(posedge clk); #1;
        trap_req = 0; imem_ready = 1;
        @(negedge clk);
        n_tests++;
        if (pc_cur !== TVEC || flush_if !== 1'b1 || stall_cnt !== 32'd4 || redirect_cnt !== 16'd1 || trap_epc !== 32'h40) begin
            n_fail++; $display("FAIL wait_after pc=%h fif=%b sc=%0d rc=%0d epc=%h exp %h/1/4/1/40", pc_cur, flush_if, stall_cnt, redirect_cnt, trap_epc, TVEC);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_trap();
        do_reset();
        set_pc(32'h20);
        redirect_valid = 1; redirect_pc = 32'h80;
        @(posedge clk); #1;
        redirect_valid = 0; trap_req = 1;
        @(negedge clk);
        n_tests++;
        if (pc_sel !== 2'b10 || pc_we !== 1'b1 || pc_next !== TVEC || flush_if !== 1'b1) begin
            n_fail++; $display("FAIL flush_trap sel=%b we=%b next=%h fif=%b exp 10/1/%h/1", pc_sel, pc_we, pc_next, flush_if, TVEC);
        end
        @(posedge clk); #1;
        trap_req = 0;
        for (int k = 0; k < FLUSH_N; k++) begin
            @(negedge clk);
            n_tests++;
            if ({if_valid, flush_id, pc_we} !== 3'b010) begin
                n_fail++; $display("FAIL flush_reload k=%0d got=%b exp=010", k, {if_valid, flush_id, pc_we});
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_tests++;
        if (if_valid !== 1'b1 || pc_cur !== TVEC || trap_epc !== 32'h80 || redirect_cnt !== 16'd2) begin
            n_fail++; $display("FAIL flush_exit vld=%b pc=%h epc=%h rc=%0d exp 1/%h/80/2", if_valid, pc_cur, trap_epc, redirect_cnt, TVEC);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap_halt();
        do_reset();
        set_pc(32'hFFFF_FFFC);
        @(negedge clk);
        n_tests++;
        if (pc_sel !== 2'b00 || pc_next !== 32'd0) begin
            n_fail++; $display("FAIL wrap sel=%b next=%h exp 00/0", pc_sel, pc_next);
        end
        @(posedge clk); #1;
        halt_req = 1;
        @(negedge clk);
        n_tests++;
        if (pc_we !== 1'b0 || pc_cur !== 32'd0) begin
            n_fail++; $display("FAIL halt_req we=%b pc=%h exp 0/0", pc_we, pc_cur);
        end
        @(posedge clk); #1;
        halt_req = 0; trap_req = 1; redirect_valid = 1; redirect_pc = 32'h200;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if ({halted, pc_we, pc_rev, imem_req} !== 4'b1000) begin
                n_fail++; $display("FAIL halt_hold k=%0d got=%b exp=1000", k, {halted, pc_we, pc_rev, imem_req});
            end
            @(posedge clk); #1;
        end
        trap_req = 0; redirect_valid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        n_tests++;
        if (halted !== 1'b0 || imem_req !== 1'b1) begin
            n_fail++; $display("FAIL halt_exit hlt=%b req=%b exp 0/1", halted, imem_req);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random(input int ncyc);
        mdl_t e;
        do_reset();
        for (int i = 0; i < ncyc; i++) begin
            rst            = ($urandom_range(0, 99) < 2);
            halt_req       = ($urandom_range(0, 99) < 2);
            trap_req       = ($urandom_range(0, 99) < 8);
            redirect_valid = ($urandom_range(0, 99) < 15);
            redirect_pc    = $urandom();
            if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
            replay         = ($urandom_range(0, 99) < 10);
            stall          = ($urandom_range(0, 99) < 15);
            imem_ready     = ($urandom_range(0, 99) < 75);
            @(negedge clk);
            e = model_eval();
            n_tests++;
            if ({pc_we, pc_rev, pc_sel, imem_req, if_valid, flush_if, flush_id, misalign, halted} !==
                {e.we, e.rev, e.sel, e.req, e.valid, e.fif, e.fid, e.mis, e.hlt}) begin
                n_fail++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", i,
                    {pc_we, pc_rev, pc_sel, imem_req, if_valid, flush_if, flush_id, misalign, halted},
                    {e.we, e.rev, e.sel, e.req, e.valid, e.fif, e.fid, e.mis, e.hlt});
            end
            n_tests++;
            if (pc_next !== e.nxt) begin n_fail++; $display("FAIL rnd_next cyc=%0d got=%h exp=%h", i, pc_next, e.nxt); end
            n_tests++;
            if (trap_epc !== m_epc) begin n_fail++; $display("FAIL rnd_epc cyc=%0d got=%h exp=%h", i, trap_epc, m_epc); end
            n_tests++;
            if (stall_cnt !== m_scnt[31:0] || redirect_cnt !== m_rcnt[15:0]) begin
                n_fail++; $display("FAIL rnd_cnt cyc=%0d sc=%0d rc=%0d exp %0d/%0d", i, stall_cnt, redirect_cnt, m_scnt, m_rcnt);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sat_counter();
        test_boot_seq();
        test_redirect();
        test_misalign();
        test_replay_stall();
        test_wait_mem();
        test_flush_trap();
        test_wrap_halt();
        test_random(800);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
